// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch controller and its BCD counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam int                 BCD_W        = 4;
    localparam logic [BCD_W-1:0]   DIGIT_MAX    = 4'd9;
    localparam logic [BCD_W-1:0]   SEC_TENS_MAX = 4'd5;
    localparam logic [2*BCD_W-1:0] HUND_LAST    = {DIGIT_MAX, DIGIT_MAX};
    localparam logic [2*BCD_W-1:0] SEC_LAST     = {SEC_TENS_MAX, DIGIT_MAX};

    // Two-digit BCD increment that rolls to 00 after 'last'; digits never leave 0..9.
    function automatic logic [2*BCD_W-1:0] bcd2_inc(input logic [2*BCD_W-1:0] v,
                                                   input logic [2*BCD_W-1:0] last);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = v[2*BCD_W-1:BCD_W];
        ones = v[BCD_W-1:0];
        if (v == last)
            return '0;
        else if (ones == DIGIT_MAX)
            return {tens + 4'd1, 4'd0};
        else
            return {tens, ones + 4'd1};
    endfunction

endpackage

// File: rtl/stopwatch_bcd_cnt.sv
// BCD mm:ss.hh counter; advances one hundredth per en, wraps to zero after MIN_WRAP-1:59.99.
// Latency: outputs update on the edge where en is sampled high; clr wins over en.
// Backpressure: none.
module stopwatch_bcd_cnt
    import stopwatch_pkg::*;
#(
    parameter int MIN_WRAP = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    output logic [2*BCD_W-1:0]   hund,
    output logic [2*BCD_W-1:0]   sec,
    output logic [2*BCD_W-1:0]   min
);

    localparam logic [2*BCD_W-1:0] MIN_LAST = {4'((MIN_WRAP - 1) / 10), 4'((MIN_WRAP - 1) % 10)};

    logic sec_en;
    logic min_en;

    assign sec_en = en && (hund == HUND_LAST);
    assign min_en = sec_en && (sec == SEC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hund <= '0;
            sec  <= '0;
            min  <= '0;
        end else if (clr) begin
            hund <= '0;
            sec  <= '0;
            min  <= '0;
        end else begin
            if (en)     hund <= bcd2_inc(hund, HUND_LAST);
            if (sec_en) sec  <= bcd2_inc(sec, SEC_LAST);
            if (min_en) min  <= bcd2_inc(min, MIN_LAST);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button/tick edge detect, CLEAR/RUN/PAUSE/LAP FSM, lap snapshot, display mux.
// Latency: a rise seen at an edge changes state/count on that edge; outputs follow combinationally.
// Backpressure: none; inputs are levels sampled every clk.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MIN_WRAP = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_in,
    input  logic                 strtstop,
    input  logic                 lap_load,
    input  logic                 clr,
    output logic                 run,
    output logic                 lap_hold,
    output logic [2*BCD_W-1:0]   hund,
    output logic [2*BCD_W-1:0]   sec,
    output logic [2*BCD_W-1:0]   min
);

    state_t state;
    state_t next_state;

    logic primed;
    logic tick_q, ss_q, lap_q;
    logic tick_rise, ss_rise, lap_rise;
    logic cnt_en, cnt_clr;

    logic [2*BCD_W-1:0] live_hund, live_sec, live_min;
    logic [2*BCD_W-1:0] snap_hund, snap_sec, snap_min;

    // primed masks the first clock after reset so levels already high do not look like rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed <= 1'b0;
            tick_q <= 1'b0;
            ss_q   <= 1'b0;
            lap_q  <= 1'b0;
        end else begin
            primed <= 1'b1;
            tick_q <= tick_in;
            ss_q   <= strtstop;
            lap_q  <= lap_load;
        end
    end

    assign tick_rise = primed && tick_in  && !tick_q;
    assign ss_rise   = primed && strtstop && !ss_q;
    assign lap_rise  = primed && lap_load && !lap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_CLEAR;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: if (ss_rise) next_state = ST_RUN;
            ST_RUN: begin
                if (ss_rise)       next_state = ST_PAUSE;
                else if (lap_rise) next_state = ST_LAP;
            end
            ST_PAUSE: begin
                if (ss_rise)       next_state = ST_RUN;
                else if (lap_rise) next_state = ST_CLEAR;
            end
            ST_LAP: begin
                if (ss_rise)       next_state = ST_PAUSE;
                else if (lap_rise) next_state = ST_RUN;
            end
            default: next_state = ST_CLEAR;
        endcase
        if (clr) next_state = ST_CLEAR;
    end

    // Count gating uses the pre-transition state, so a tick coincident with stop still counts.
    assign cnt_en  = tick_rise && ((state == ST_RUN) || (state == ST_LAP));
    assign cnt_clr = (next_state == ST_CLEAR);

    stopwatch_bcd_cnt #(
        .MIN_WRAP (MIN_WRAP)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .hund  (live_hund),
        .sec   (live_sec),
        .min   (live_min)
    );

    // Snapshot takes the counter value from before the entry edge, excluding a same-edge tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_hund <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
        end else if ((state != ST_LAP) && (next_state == ST_LAP)) begin
            snap_hund <= live_hund;
            snap_sec  <= live_sec;
            snap_min  <= live_min;
        end
    end

    always_comb begin
        run      = (state == ST_RUN) || (state == ST_LAP);
        lap_hold = (state == ST_LAP);
        hund     = live_hund;
        sec      = live_sec;
        min      = live_min;
        if (state == ST_LAP) begin
            hund = snap_hund;
            sec  = snap_sec;
            min  = snap_min;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: per-cycle vector table plus multi-cycle sequences.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in, strtstop, lap_load, clr;
    logic       run, lap_hold;
    logic [7:0] hund, sec, min;
    logic       run_w, lap_hold_w;
    logic [7:0] hund_w, sec_w, min_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .strtstop(strtstop),
        .lap_load(lap_load), .clr(clr), .run(run), .lap_hold(lap_hold),
        .hund(hund), .sec(sec), .min(min)
    );

    // Short-wrap instance so the minute wrap is reachable in a bounded run.
    stopwatch_ctrl #(.MIN_WRAP(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .strtstop(strtstop),
        .lap_load(lap_load), .clr(clr), .run(run_w), .lap_hold(lap_hold_w),
        .hund(hund_w), .sec(sec_w), .min(min_w)
    );

    typedef struct {
        logic       ss, lap, cl, tk;
        logic       e_run, e_lap;
        logic [7:0] e_hund;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ss, input logic lap, input logic cl, input logic tk,
                       input logic er, input logic el, input logic [7:0] eh);
        vec_t v;
        v.ss = ss; v.lap = lap; v.cl = cl; v.tk = tk;
        v.e_run = er; v.e_lap = el; v.e_hund = eh;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_disp(input string name, input logic er, input logic el,
                            input logic [7:0] em, input logic [7:0] es, input logic [7:0] eh);
        chk(name, {6'd0, run, lap_hold, min, sec, hund}, {6'd0, er, el, em, es, eh});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick_in = 1'b1; step();
        tick_in = 1'b0; step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic press_ss();
        strtstop = 1'b1; step();
        strtstop = 1'b0; step();
    endtask

    task automatic press_lap();
        lap_load = 1'b1; step();
        lap_load = 1'b0; step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; step(); step();
        rst_n = 1'b1; step();
    endtask

    initial begin
        rst_n = 1'b0; tick_in = 1'b0; strtstop = 1'b0; lap_load = 1'b0; clr = 1'b0;
        step(); step();
        chk_disp("reset_state", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        step();

        //   ss    lap   clr   tick  run   lap   hund
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        foreach (tbl[i]) begin
            strtstop = tbl[i].ss; lap_load = tbl[i].lap; clr = tbl[i].cl; tick_in = tbl[i].tk;
            step();
            chk_disp($sformatf("vec%0d", i), tbl[i].e_run, tbl[i].e_lap, 8'h00, 8'h00, tbl[i].e_hund);
        end
        strtstop = 1'b0; lap_load = 1'b0; clr = 1'b0; tick_in = 1'b0;
        step();

        // Start and count 150 hundredths.
        press_ss();
        ticks(150);
        chk_disp("run_150", 1'b1, 1'b0, 8'h00, 8'h01, 8'h50);

        clr = 1'b1; step(); clr = 1'b0; step();
        chk_disp("clr_pulse", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // Lap freeze and release.
        press_ss();
        ticks(42);
        chk_disp("run_42", 1'b1, 1'b0, 8'h00, 8'h00, 8'h42);
        press_lap();
        ticks(30);
        chk_disp("lap_frozen", 1'b1, 1'b1, 8'h00, 8'h00, 8'h42);
        press_lap();
        chk_disp("lap_release", 1'b1, 1'b0, 8'h00, 8'h00, 8'h72);

        // Minute carry on the default instance and full wrap on the short-wrap one.
        do_reset();
        press_ss();
        ticks(11999);
        chk_disp("pre_wrap", 1'b1, 1'b0, 8'h01, 8'h59, 8'h99);
        chk("pre_wrap_w", {run_w, min_w, sec_w, hund_w}, {1'b1, 8'h01, 8'h59, 8'h99});
        do_tick();
        chk_disp("min_carry", 1'b1, 1'b0, 8'h02, 8'h00, 8'h00);
        chk("wrap_w", {run_w, lap_hold_w, min_w, sec_w, hund_w}, {1'b1, 1'b0, 8'h00, 8'h00, 8'h00});

        // Reset in the middle of a lap, with strtstop held through release.
        press_lap();
        ticks(5);
        chk_disp("lap_before_rst", 1'b1, 1'b1, 8'h02, 8'h00, 8'h00);
        strtstop = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_disp("async_rst", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        chk_disp("held_no_start", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        strtstop = 1'b0; step();
        strtstop = 1'b1; step();
        chk_disp("restart", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        strtstop = 1'b0;
        do_tick();
        chk_disp("restart_tick", 1'b1, 1'b0, 8'h00, 8'h00, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
